// File: rtl/pwm_wb_sequencer.sv
// Wishbone fade sequencer for LitePWM with a host-priority 2:1 bus arbiter.
// Ramps the PWM width as a triangle wave between min_w and max_w.
module pwm_wb_sequencer #(
  parameter logic [16:0] ADDR_ENABLE = 17'h00000,
  parameter logic [16:0] ADDR_WIDTH  = 17'h00004,
  parameter logic [16:0] ADDR_PERIOD = 17'h00008,
  parameter int unsigned TICK_DIV    = 1000
) (
  input  logic        WB_CLK,
  input  logic        WB_RST_n,
  input  logic [16:0] h_adr,
  input  logic [31:0] h_dat_w,
  input  logic [3:0]  h_sel,
  input  logic        h_cyc,
  input  logic        h_stb,
  input  logic        h_we,
  output logic [31:0] h_dat_r,
  output logic        h_ack,
  output logic [16:0] m_adr,
  output logic [31:0] m_dat_w,
  output logic [3:0]  m_sel,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  input  logic [31:0] m_dat_r,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_val,
  input  logic [31:0] min_w,
  input  logic [31:0] max_w,
  input  logic [15:0] step,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PER  = 3'd1;
  localparam logic [2:0] S_EN   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WID  = 3'd4;
  localparam logic [2:0] S_DIS  = 3'd5;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_HOST = 2'd1;
  localparam logic [1:0] O_SEQ  = 2'd2;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  logic [2:0]  state;
  logic [1:0]  owner;
  logic [31:0] cur;
  logic        dir_up;
  logic [31:0] cnt;
  logic        stop_pend;

  logic        host_req;
  logic        seq_req;
  logic        own_host;
  logic        own_seq;
  logic        done;
  logic        go_dis;
  logic [16:0] seq_adr;
  logic [31:0] seq_dat;
  logic [31:0] cur_nx;
  logic        dir_nx;
  logic [32:0] up_sum;
  logic [32:0] dn_lim;

  assign host_req = h_cyc & h_stb;
  assign seq_req  = (state == S_PER) | (state == S_EN)
                  | (state == S_WID) | (state == S_DIS);
  assign own_host = (owner == O_HOST);
  assign own_seq  = (owner == O_SEQ);
  assign done     = own_seq & (m_ack | m_err);
  assign go_dis   = stop_pend | stop;
  assign busy     = (state != S_IDLE);

  assign h_ack   = own_host & (m_ack | m_err);
  assign h_dat_r = m_dat_r;

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      owner <= O_NONE;
    end else begin
      case (owner)
        O_NONE: begin
          if (host_req)     owner <= O_HOST;
          else if (seq_req) owner <= O_SEQ;
        end
        default: begin
          if (m_ack | m_err) owner <= O_NONE;
        end
      endcase
    end
  end

  always_comb begin
    seq_adr = '0;
    seq_dat = '0;
    unique case (1'b1)
      (state == S_PER): begin
        seq_adr = ADDR_PERIOD;
        seq_dat = period_val;
      end
      (state == S_EN): begin
        seq_adr = ADDR_ENABLE;
        seq_dat = 32'd1;
      end
      (state == S_WID): begin
        seq_adr = ADDR_WIDTH;
        seq_dat = cur;
      end
      (state == S_DIS): begin
        seq_adr = ADDR_ENABLE;
        seq_dat = 32'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_adr   = '0;
    m_dat_w = '0;
    m_sel   = '0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    unique case (1'b1)
      own_host: begin
        m_adr   = h_adr;
        m_dat_w = h_dat_w;
        m_sel   = h_sel;
        m_cyc   = h_cyc;
        m_stb   = h_stb;
        m_we    = h_we;
      end
      own_seq: begin
        m_adr   = seq_adr;
        m_dat_w = seq_dat;
        m_sel   = 4'hF;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // Limit compares are 33-bit so cur+step and min_w+step never wrap.
  assign up_sum = {1'b0, cur} + {17'b0, step};
  assign dn_lim = {1'b0, min_w} + {17'b0, step};

  always_comb begin
    cur_nx = cur;
    dir_nx = dir_up;
    if (min_w >= max_w) begin
      cur_nx = min_w;
    end else if (dir_up) begin
      if (up_sum >= {1'b0, max_w}) begin
        cur_nx = max_w;
        dir_nx = 1'b0;
      end else begin
        cur_nx = up_sum[31:0];
      end
    end else if ({1'b0, cur} <= dn_lim) begin
      cur_nx = min_w;
      dir_nx = 1'b1;
    end else begin
      cur_nx = cur - {16'b0, step};
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      dir_up    <= 1'b1;
      cnt       <= '0;
      stop_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (done & m_err) err <= 1'b1;
      if (stop & busy) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          cnt       <= '0;
          if (start) state <= S_PER;
        end
        S_PER: begin
          if (done) state <= go_dis ? S_DIS : S_EN;
        end
        S_EN: begin
          if (done) begin
            cur    <= min_w;
            dir_up <= 1'b1;
            cnt    <= '0;
            state  <= go_dis ? S_DIS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (go_dis) begin
            state <= S_DIS;
          end else if (cnt == TICK_LAST) begin
            cnt   <= '0;
            state <= S_WID;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WID: begin
          if (done) begin
            cur    <= cur_nx;
            dir_up <= dir_nx;
            state  <= go_dis ? S_DIS : S_WAIT;
          end
        end
        S_DIS: begin
          if (done) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_wb_sequencer.sv
// Self-checking bench for pwm_wb_sequencer with a LitePWM-like slave model.
// Directed table rows, multi-cycle corner sequences and random fades.
module tb_pwm_wb_sequencer;

  localparam logic [16:0] A_EN  = 17'h00000;
  localparam logic [16:0] A_WID = 17'h00004;
  localparam logic [16:0] A_PER = 17'h00008;
  localparam int TICK = 4;

  logic clk = 0;
  logic rst_n = 0;
  logic [16:0] h_adr = 0;
  logic [31:0] h_dat_w = 0;
  logic [3:0] h_sel = 0;
  logic h_cyc = 0, h_stb = 0, h_we = 0;
  logic [31:0] h_dat_r;
  logic h_ack;
  logic [16:0] m_adr;
  logic [31:0] m_dat_w;
  logic [3:0] m_sel;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_dat_r;
  logic m_ack, m_err;
  logic start = 0, stop = 0;
  logic [31:0] period_val = 1000;
  logic [31:0] min_w = 0, max_w = 0;
  logic [15:0] step = 0;
  logic busy, err;

  pwm_wb_sequencer #(
    .ADDR_ENABLE(A_EN), .ADDR_WIDTH(A_WID),
    .ADDR_PERIOD(A_PER), .TICK_DIV(TICK)
  ) dut (
    .WB_CLK(clk), .WB_RST_n(rst_n),
    .h_adr(h_adr), .h_dat_w(h_dat_w), .h_sel(h_sel),
    .h_cyc(h_cyc), .h_stb(h_stb), .h_we(h_we),
    .h_dat_r(h_dat_r), .h_ack(h_ack),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .start(start), .stop(stop), .period_val(period_val),
    .min_w(min_w), .max_w(max_w), .step(step),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t wlog[$];
  logic [31:0] regs [0:3];
  int ack_delay = 1;
  int wcnt;
  int err_tok = 0;
  int err_seen = 0;
  logic [16:0] err_adr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack   <= 0;
      m_err   <= 0;
      m_dat_r <= 0;
      wcnt    <= 0;
      for (int i = 0; i < 4; i++) regs[i] <= 0;
    end else begin
      m_ack <= 0;
      m_err <= 0;
      if (m_cyc && m_stb && !m_ack && !m_err) begin
        if (wcnt >= ack_delay - 1) begin
          wcnt <= 0;
          if (err_tok != err_seen && m_adr == err_adr) begin
            m_err    <= 1;
            err_seen <= err_tok;
          end else begin
            m_ack <= 1;
          end
          if (m_we) begin
            regs[m_adr[3:2]] <= m_dat_w;
            wlog.push_back('{adr: m_adr, dat: m_dat_w});
          end else begin
            m_dat_r <= regs[m_adr[3:2]];
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  bit mon_en = 0;
  int gap_cnt = 0;
  always @(negedge clk) if (mon_en && !busy) gap_cnt++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int b = 0;
    while (wlog.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    ok = (wlog.size() >= n);
  endtask

  task automatic pulse_start(input bit with_stop);
    @(posedge clk);
    #1 start = 1; stop = with_stop;
    @(posedge clk);
    #1 start = 0; stop = 0;
  endtask

  task automatic stop_seq(input string tag);
    int b = 0;
    @(posedge clk);
    #1 stop = 1;
    @(posedge clk);
    #1 stop = 0;
    while (busy && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_idle"}, {31'b0, busy}, 0);
    chk({tag, "_dis_adr"}, {15'b0, wlog[wlog.size()-1].adr}, {15'b0, A_EN});
    chk({tag, "_dis_dat"}, wlog[wlog.size()-1].dat, 0);
  endtask

  task automatic host_read(input logic [16:0] a, output logic [31:0] d,
                           output bit ok, output bit first);
    int b = 0;
    h_adr = a; h_we = 0; h_sel = 4'hF; h_cyc = 1; h_stb = 1;
    @(posedge clk);
    @(negedge clk);
    first = m_cyc && !m_we && (m_adr == a);
    while (!h_ack && b < 200) begin
      @(negedge clk);
      b++;
    end
    ok = h_ack;
    d = h_dat_r;
    @(posedge clk);
    #1 h_cyc = 0; h_stb = 0;
  endtask

  // Triangle fade from the rules: climb by step, clamp at max, fall, clamp at min.
  function automatic void model(input logic [31:0] mn, mx,
                                input logic [15:0] st,
                                output logic [31:0] e [0:7]);
    longint c = mn;
    bit up = 1;
    for (int i = 0; i < 8; i++) begin
      e[i] = c[31:0];
      if (mn >= mx) c = mn;
      else if (up) begin
        if (c + st >= mx) begin c = mx; up = 0; end
        else c = c + st;
      end else begin
        if (c <= longint'(mn) + st) begin c = mn; up = 1; end
        else c = c - st;
      end
    end
  endfunction

  task automatic run_fade(input logic [31:0] mn, mx, input logic [15:0] st,
                          input logic [31:0] e [0:7], input bit both,
                          input string tag);
    int base, g0;
    bit ok;
    min_w = mn; max_w = mx; step = st; period_val = 1000;
    base = wlog.size();
    pulse_start(both);
    g0 = gap_cnt;
    mon_en = 1;
    wait_log(base + 10, 3000, ok);
    mon_en = 0;
    chk({tag, "_done"}, {31'b0, ok}, 1);
    if (ok) begin
      chk({tag, "_per_adr"}, {15'b0, wlog[base].adr}, {15'b0, A_PER});
      chk({tag, "_per_dat"}, wlog[base].dat, 1000);
      chk({tag, "_en_adr"}, {15'b0, wlog[base+1].adr}, {15'b0, A_EN});
      chk({tag, "_en_dat"}, wlog[base+1].dat, 1);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_wadr%0d", tag, i),
            {15'b0, wlog[base+2+i].adr}, {15'b0, A_WID});
        chk($sformatf("%s_w%0d", tag, i), wlog[base+2+i].dat, e[i]);
      end
    end
    chk({tag, "_busy_hold"}, gap_cnt - g0, 0);
    stop_seq(tag);
  endtask

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [15:0] st;
    logic [31:0] w [0:7];
  } vec_t;

  vec_t vt [0:3];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, b;
    bit ok, first;
    logic [31:0] d;
    logic [31:0] e [0:7];
    logic [31:0] mn, mx;
    logic [15:0] st;

    vt[0] = '{mn: 100, mx: 400, st: 100,
              w: '{100, 200, 300, 400, 300, 200, 100, 200}};
    vt[1] = '{mn: 0, mx: 250, st: 100,
              w: '{0, 100, 200, 250, 150, 50, 0, 100}};
    vt[2] = '{mn: 300, mx: 200, st: 50,
              w: '{300, 300, 300, 300, 300, 300, 300, 300}};
    vt[3] = '{mn: 50, mx: 100, st: 0,
              w: '{50, 50, 50, 50, 50, 50, 50, 50}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", {31'b0, m_cyc}, 0);
    chk("rst_stb", {31'b0, m_stb}, 0);
    chk("rst_we", {31'b0, m_we}, 0);
    chk("rst_adr", {15'b0, m_adr}, 0);
    chk("rst_hack", {31'b0, h_ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst_n = 1;

    for (int r = 0; r < 4; r++)
      run_fade(vt[r].mn, vt[r].mx, vt[r].st, vt[r].w, r == 0,
               $sformatf("vec%0d", r));

    for (int r = 0; r < 5; r++) begin
      mn = $urandom_range(0, 300);
      mx = $urandom_range(0, 600);
      st = 16'($urandom_range(0, 150));
      model(mn, mx, st, e);
      run_fade(mn, mx, st, e, 0, $sformatf("rnd%0d", r));
    end

    min_w = 100; max_w = 400; step = 100;
    base = wlog.size();
    pulse_start(0);
    wait_log(base + 2, 200, ok);
    repeat (1 + TICK) @(posedge clk);
    #1;
    host_read(A_PER, d, ok, first);
    chk("host_first", {31'b0, first}, 1);
    chk("host_ack", {31'b0, ok}, 1);
    chk("host_dat", d, 1000);
    wait_log(base + 3, 200, ok);
    chk("host_seq_adr", {15'b0, wlog[base+2].adr}, {15'b0, A_WID});
    chk("host_seq_dat", wlog[base+2].dat, 100);
    stop_seq("host");

    ack_delay = 5;
    base = wlog.size();
    pulse_start(0);
    b = 0;
    while (!(m_cyc && m_adr == A_WID) && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("stall_seen", {31'b0, m_cyc}, 1);
    stop = 1;
    @(posedge clk);
    #1 stop = 0;
    wait_log(base + 4, 500, ok);
    chk("stall_done", {31'b0, ok}, 1);
    chk("stall_wid_adr", {15'b0, wlog[base+2].adr}, {15'b0, A_WID});
    chk("stall_wid_dat", wlog[base+2].dat, 100);
    chk("stall_dis_adr", {15'b0, wlog[base+3].adr}, {15'b0, A_EN});
    chk("stall_dis_dat", wlog[base+3].dat, 0);
    chk("stall_busy_ack", {31'b0, busy}, 1);
    @(negedge clk);
    chk("stall_busy_fall", {31'b0, busy}, 0);
    ack_delay = 1;

    err_adr = A_EN;
    err_tok++;
    base = wlog.size();
    pulse_start(0);
    wait_log(base + 3, 300, ok);
    chk("err_flag", {31'b0, err}, 1);
    chk("err_cont_adr", {15'b0, wlog[base+2].adr}, {15'b0, A_WID});
    repeat (10) @(posedge clk);
    #1;
    chk("err_sticky", {31'b0, err}, 1);
    err_adr = A_PER;
    err_tok++;
    host_read(A_PER, d, ok, first);
    chk("err_host_ack", {31'b0, ok}, 1);
    stop_seq("err");

    base = wlog.size();
    pulse_start(0);
    b = 0;
    while (!m_cyc && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("arst_pre_cyc", {31'b0, m_cyc}, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_cyc", {31'b0, m_cyc}, 0);
    chk("arst_stb", {31'b0, m_stb}, 0);
    chk("arst_we", {31'b0, m_we}, 0);
    chk("arst_hack", {31'b0, h_ack}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_err", {31'b0, err}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    base = wlog.size();
    pulse_start(0);
    wait_log(base + 2, 200, ok);
    chk("arst_per_adr", {15'b0, wlog[base].adr}, {15'b0, A_PER});
    chk("arst_per_dat", wlog[base].dat, 1000);
    chk("arst_en_dat", wlog[base+1].dat, 1);
    stop_seq("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_wb_sequencer.md
# pwm_wb_sequencer

Wishbone sequencer and 2:1 bus arbiter between the EOS S3 fabric Wishbone port and the LitePWM CSR slave. It autonomously ramps the PWM width register in a triangle wave (fade) between programmed limits. It also forwards host (AHB-bridge) transactions to the same slave, giving the host priority. It sits between `qlal4s3b_cell_macro` and `LitePWM`, replacing their direct connection.

## Interface
Parameters:
- `ADDR_ENABLE`, default 17'h0000: LitePWM enable CSR address.
- `ADDR_WIDTH`, default 17'h0004: LitePWM width CSR address.
- `ADDR_PERIOD`, default 17'h0008: LitePWM period CSR address.
- `TICK_DIV`, default 1000: WB_CLK cycles between width updates. Must be ≥2.

Ports:
- `WB_CLK` in 1: the block's single clock.
- `WB_RST_n` in 1: reset, asynchronous, active-low.
- `h_adr` in 17, `h_dat_w` in 32, `h_sel` in 4, `h_cyc` in 1, `h_stb` in 1, `h_we` in 1: host Wishbone request.
- `h_dat_r` out 32, `h_ack` out 1: host Wishbone response.
- `m_adr` out 17, `m_dat_w` out 32, `m_sel` out 4, `m_cyc` out 1, `m_stb` out 1, `m_we` out 1: Wishbone master to LitePWM.
- `m_dat_r` in 32, `m_ack` in 1, `m_err` in 1: LitePWM response.
- `start` in 1: one-cycle pulse that begins the fade.
- `stop` in 1: one-cycle pulse that ends the fade.
- `period_val` in 32: PWM period value.
- `min_w` in 32, `max_w` in 32: fade limits.
- `step` in 16: width increment per tick, zero-extended.
- `busy` out 1: sequencer is not IDLE.
- `err` out 1: sticky flag set by `m_err` on any sequencer transaction.

## Operation
- Sequencer states: IDLE, WR_PERIOD, WR_EN, WAIT_TICK, WR_WIDTH, WR_DIS.
- IDLE to WR_PERIOD on `start`. IDLE ignores `stop`.
- WR_PERIOD writes `period_val` to ADDR_PERIOD.
- WR_EN writes 1 to ADDR_ENABLE. It loads `cur` = `min_w` and `dir` = up.
- WAIT_TICK counts TICK_DIV cycles, then goes to WR_WIDTH.
- WR_WIDTH writes `cur` to ADDR_WIDTH, updates `cur`, then returns to WAIT_TICK.
- WR_DIS writes 0 to ADDR_ENABLE, then goes to IDLE.
- A WR_* state completes on `m_ack` or `m_err`. `m_err` sets `err` and the sequence proceeds.
- All sequencer writes use `m_sel` = 4'hF and `m_we` = 1.
- `stop` while busy is latched into `stop_pend`:
  - An in-flight write always completes.
  - From WAIT_TICK, the next state is WR_DIS immediately.
  - From any WR_* state, the next state is WR_DIS after completion.
- `start` while busy is ignored. `start` and `stop` in the same cycle in IDLE: start is taken and `stop` is ignored.
- Width update (32-bit unsigned, no wrap):
  - Up: if `cur` + step ≥ `max_w` (computed 33-bit), then `cur` = `max_w` and `dir` = down. Otherwise `cur` += step.
  - Down: if `cur` ≤ `min_w` + step (33-bit), then `cur` = `min_w` and `dir` = up. Otherwise `cur` −= step.
  - If `min_w` ≥ `max_w`, `cur` holds at `min_w`.
  - If `step` = 0, `cur` is constant.
- Arbiter: `owner` register with values NONE, HOST, SEQ.
  - In NONE, host request (`h_cyc` & `h_stb`) wins over a sequencer request. No round-robin.
  - An owner holds the bus until `m_ack` or `m_err` is sampled, then returns to NONE on that edge.
  - A sequencer request waiting for grant is never dropped.
- Bus mux: `m_*` outputs are driven combinationally from the current owner. In NONE all `m_*` outputs are 0.
- `h_ack` = `m_ack` | `m_err` when owner is HOST, else 0. `h_dat_r` = `m_dat_r`.
- The host never sees an error signal; its error is reported as ack.

## Timing
- Reset values: all `m_*` = 0, `h_ack` = 0, `h_dat_r` follows `m_dat_r`, `busy` = 0, `err` = 0, `cur` = 0, owner = NONE, state = IDLE.
- Asserting `WB_RST_n` low mid-transaction drops `m_cyc` immediately. No completion is attempted.
- `start` sampled at edge 0 gives state WR_PERIOD and `busy` = 1 after edge 0. SEQ is granted at edge 1, and `m_cyc` = 1 from edge 1 if the bus is free.
- Host request first seen at edge k: grant at edge k, `m_cyc` high after edge k. Earliest `h_ack` is the cycle after that, i.e. one added cycle versus a direct connection.
- Back-to-back: after release at an edge, a new grant can occur at the next edge. There is a minimum of one idle cycle between transactions.
- Width update period is TICK_DIV cycles plus the bus latency of the WR_WIDTH write.

## Test plan
- Reset release; `start` with period=1000, min=100, max=400, step=100, slave acks in 1 cycle:
  - Writes in order: PERIOD=1000, ENABLE=1, then WIDTH = 100, 200, 300, 400, 300, 200, 100, 200.
  - `busy` = 1 throughout.
- Overshoot clamp: min=0, max=250, step=100 → widths 0, 100, 200, 250, 150, 50, 0, 100.
- Host read of ADDR_PERIOD issued in the same cycle the sequencer requests WR_WIDTH:
  - Host is granted first and `h_ack` returns 1000.
  - The sequencer write follows with the correct value; no write is lost.
- `stop` during a stalled WR_WIDTH (slave ack delayed 5 cycles):
  - The write completes, then ENABLE=0 is written.
  - `busy` falls the cycle after that ack.
- `m_err` on WR_EN:
  - `err` = 1 and stays set.
  - The sequence continues to WR_WIDTH; a host access ending in `m_err` returns `h_ack` = 1.
- `WB_RST_n` low while `m_cyc` = 1:
  - All outputs go to zero asynchronously.
  - After release, `start` restarts cleanly from WR_PERIOD.
